// File: rtl/aes_pipe_sched_if.sv
// Handshake and status bundle between the block controller and the AES pipeline scheduler.
interface aes_pipe_sched_if #(
   parameter int unsigned DEPTH = 11,
   parameter int unsigned CNT_W = 32
);
   logic             aes_enable;
   logic             in_valid;
   logic             out_ready;
   logic             flush;
   logic             drain;
   logic             in_ready;
   logic             advance;
   logic [DEPTH-1:0] stage_valid;
   logic             data_output;
   logic             pipeline_full;
   logic [3:0]       occupancy;
   logic [CNT_W-1:0] ctr_value;
   logic             drain_done;
   logic             ovf_err;

   modport master (
      output aes_enable, in_valid, out_ready, flush, drain,
      input  in_ready, advance, stage_valid, data_output, pipeline_full,
             occupancy, ctr_value, drain_done, ovf_err
   );

   modport slave (
      input  aes_enable, in_valid, out_ready, flush, drain,
      output in_ready, advance, stage_valid, data_output, pipeline_full,
             occupancy, ctr_value, drain_done, ovf_err
   );
endinterface

// File: rtl/aes_pipe_sched.sv
// Occupancy/valid scheduler for a DEPTH-stage AES pipeline with CTR-mode block counter.
module aes_pipe_sched #(
   parameter int unsigned DEPTH = 11,
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk,
   input  logic             n_rst,
   aes_pipe_sched_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      FLUSH = 2'd3
   } state_t;

   state_t           state;
   state_t           state_next;

   logic [DEPTH-1:0] stage_valid;
   logic [3:0]       occupancy;
   logic [CNT_W-1:0] ctr_value;
   logic             ovf_err;

   logic             active;
   logic             advance;
   logic             in_ready;
   logic             accept;
   logic             retire;
   logic             drain_done;
   logic             clear;

   always_comb begin
      active     = (state == RUN) || (state == DRAIN);
      advance    = bus.aes_enable && !(stage_valid[DEPTH-1] && !bus.out_ready) && active;
      in_ready   = advance && (state == RUN);
      accept     = bus.in_valid && in_ready;
      retire     = advance && stage_valid[DEPTH-1];
      drain_done = (state == DRAIN) && (occupancy == '0) && !bus.flush;
      // In-flight blocks are dropped on the edge that samples flush, so FLUSH
      // and the following IDLE never see stale occupancy.
      clear      = bus.flush || (state == FLUSH);
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      if (bus.flush) begin
         state_next = FLUSH;
      end else begin
         case (state)
            IDLE:    if (bus.aes_enable) state_next = RUN;
            RUN:     if (bus.drain) state_next = DRAIN;
            DRAIN:   if (occupancy == '0) state_next = IDLE;
            FLUSH:   state_next = IDLE;
            default: state_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         stage_valid <= '0;
         occupancy   <= '0;
         ctr_value   <= '0;
         ovf_err     <= 1'b0;
      end else if (clear) begin
         stage_valid <= '0;
         occupancy   <= '0;
         ctr_value   <= '0;
         ovf_err     <= 1'b0;
      end else begin
         if (advance) begin
            stage_valid <= {stage_valid[DEPTH-2:0], accept};
         end
         if (accept && !retire) begin
            occupancy <= occupancy + 4'd1;
         end else if (retire && !accept) begin
            occupancy <= occupancy - 4'd1;
         end
         if (accept) begin
            ctr_value <= ctr_value + CNT_W'(1);
         end
         if ((state == RUN) && bus.in_valid && !in_ready) begin
            ovf_err <= 1'b1;
         end
      end
   end

   assign bus.in_ready      = in_ready;
   assign bus.advance       = advance;
   assign bus.stage_valid   = stage_valid;
   assign bus.data_output   = retire;
   assign bus.pipeline_full = (occupancy == 4'(DEPTH));
   assign bus.occupancy     = occupancy;
   assign bus.ctr_value     = ctr_value;
   assign bus.drain_done    = drain_done;
   assign bus.ovf_err       = ovf_err;

endmodule

// File: tb/tb_aes_pipe_sched.sv
// Directed bench for aes_pipe_sched: latency, streaming, stall, flush, drain, counter wrap, reset.
module tb_aes_pipe_sched;

   logic clk;
   logic n_rst;
   int   n_checks;
   int   n_errors;

   aes_pipe_sched_if #(.DEPTH(11), .CNT_W(32)) bus ();
   aes_pipe_sched_if #(.DEPTH(11), .CNT_W(4))  bus2 ();

   aes_pipe_sched #(.DEPTH(11), .CNT_W(32)) dut (
      .clk   (clk),
      .n_rst (n_rst),
      .bus   (bus)
   );

   // Narrow counter instance so the wrap can be reached in a few cycles.
   aes_pipe_sched #(.DEPTH(11), .CNT_W(4)) dut_w (
      .clk   (clk),
      .n_rst (n_rst),
      .bus   (bus2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic go_run_clean();
      bus.in_valid = 1'b0;
      bus.drain    = 1'b0;
      bus.flush    = 1'b1;
      next_cycle();
      bus.flush      = 1'b0;
      bus.aes_enable = 1'b1;
      next_cycle();
      next_cycle();
   endtask

   initial begin
      #200000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1);
   end

   initial begin
      int retired;
      int acc;
      int ret;
      n_checks = 0;
      n_errors = 0;

      n_rst           = 1'b0;
      bus.aes_enable  = 1'b1;
      bus.in_valid    = 1'b1;
      bus.out_ready   = 1'b1;
      bus.flush       = 1'b0;
      bus.drain       = 1'b0;
      bus2.aes_enable = 1'b0;
      bus2.in_valid   = 1'b0;
      bus2.out_ready  = 1'b1;
      bus2.flush      = 1'b0;
      bus2.drain      = 1'b0;

      // reset values, combinational outputs held low with inputs active
      @(posedge clk);
      @(negedge clk);
      check("rst_in_ready", 64'(bus.in_ready), 64'd0);
      check("rst_advance", 64'(bus.advance), 64'd0);
      check("rst_data_output", 64'(bus.data_output), 64'd0);
      check("rst_stage_valid", 64'(bus.stage_valid), 64'd0);
      check("rst_occupancy", 64'(bus.occupancy), 64'd0);
      check("rst_ctr", 64'(bus.ctr_value), 64'd0);
      check("rst_ovf", 64'(bus.ovf_err), 64'd0);
      check("rst_full", 64'(bus.pipeline_full), 64'd0);
      check("rst_drain_done", 64'(bus.drain_done), 64'd0);

      next_cycle();
      n_rst        = 1'b1;
      bus.in_valid = 1'b0;
      @(negedge clk);
      bus.in_valid = 1'b1;
      #1;
      check("idle_in_ready", 64'(bus.in_ready), 64'd0);
      bus.in_valid = 1'b0;
      next_cycle();

      // single block latency
      bus.in_valid = 1'b1;
      @(negedge clk);
      check("t1_in_ready", 64'(bus.in_ready), 64'd1);
      check("t1_ctr", 64'(bus.ctr_value), 64'd0);
      next_cycle();
      bus.in_valid = 1'b0;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         check("t1_stage_valid", 64'(bus.stage_valid), (k <= 11) ? (64'd1 << (k - 1)) : 64'd0);
         check("t1_data_output", 64'(bus.data_output), (k == 11) ? 64'd1 : 64'd0);
         check("t1_occupancy", 64'(bus.occupancy), (k <= 11) ? 64'd1 : 64'd0);
         next_cycle();
      end

      // 20-block stream
      go_run_clean();
      for (int c = 0; c <= 31; c++) begin
         bus.in_valid = (c < 20);
         acc = (c < 20) ? c : 20;
         ret = (c > 11) ? (c - 11) : 0;
         @(negedge clk);
         check("t2_in_ready", 64'(bus.in_ready), 64'd1);
         if (c < 20) check("t2_ctr", 64'(bus.ctr_value), 64'(c));
         check("t2_data_output", 64'(bus.data_output), (c >= 11 && c <= 30) ? 64'd1 : 64'd0);
         check("t2_full", 64'(bus.pipeline_full), (c >= 11 && c <= 20) ? 64'd1 : 64'd0);
         check("t2_occupancy", 64'(bus.occupancy), 64'(acc - ret));
         next_cycle();
      end

      // full pipeline stalled by tx
      for (int c = 0; c <= 10; c++) begin
         bus.in_valid = 1'b1;
         next_cycle();
      end
      for (int c = 11; c <= 15; c++) begin
         bus.in_valid  = 1'b1;
         bus.out_ready = 1'b0;
         @(negedge clk);
         check("t3_stage_valid", 64'(bus.stage_valid), 64'h7ff);
         check("t3_occupancy", 64'(bus.occupancy), 64'd11);
         check("t3_in_ready", 64'(bus.in_ready), 64'd0);
         check("t3_data_output", 64'(bus.data_output), 64'd0);
         check("t3_advance", 64'(bus.advance), 64'd0);
         check("t3_ctr", 64'(bus.ctr_value), 64'd31);
         check("t3_ovf", 64'(bus.ovf_err), (c > 11) ? 64'd1 : 64'd0);
         next_cycle();
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      retired = 0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (bus.data_output) retired++;
         next_cycle();
      end
      check("t3_retired", 64'(retired), 64'd11);
      check("t3_occ_after", 64'(bus.occupancy), 64'd0);
      check("t3_ovf_sticky", 64'(bus.ovf_err), 64'd1);

      // flush with six blocks in flight
      for (int c = 0; c < 6; c++) begin
         bus.in_valid = 1'b1;
         @(negedge clk);
         check("t4_ctr", 64'(bus.ctr_value), 64'(31 + c));
         next_cycle();
      end
      bus.in_valid = 1'b0;
      bus.flush    = 1'b1;
      @(negedge clk);
      check("t4_occupancy", 64'(bus.occupancy), 64'd6);
      next_cycle();
      bus.flush      = 1'b0;
      bus.in_valid   = 1'b1;
      bus.aes_enable = 1'b0;
      @(negedge clk);
      check("t4_flush_in_ready", 64'(bus.in_ready), 64'd0);
      check("t4_flush_data_output", 64'(bus.data_output), 64'd0);
      next_cycle();
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check("t4_idle_occupancy", 64'(bus.occupancy), 64'd0);
         check("t4_idle_ctr", 64'(bus.ctr_value), 64'd0);
         check("t4_idle_ovf", 64'(bus.ovf_err), 64'd0);
         check("t4_idle_stage_valid", 64'(bus.stage_valid), 64'd0);
         check("t4_idle_data_output", 64'(bus.data_output), 64'd0);
         check("t4_idle_in_ready", 64'(bus.in_ready), 64'd0);
         next_cycle();
      end
      bus.in_valid   = 1'b0;
      bus.aes_enable = 1'b1;
      next_cycle();

      // drain with four blocks in flight
      for (int c = 0; c < 4; c++) begin
         bus.in_valid = 1'b1;
         @(negedge clk);
         check("t5_ctr", 64'(bus.ctr_value), 64'(c));
         next_cycle();
      end
      bus.in_valid = 1'b0;
      bus.drain    = 1'b1;
      next_cycle();
      bus.drain    = 1'b0;
      bus.in_valid = 1'b1;
      for (int c = 5; c <= 15; c++) begin
         @(negedge clk);
         if (c == 5) check("t5_occupancy", 64'(bus.occupancy), 64'd4);
         check("t5_in_ready", 64'(bus.in_ready), 64'd0);
         check("t5_data_output", 64'(bus.data_output), (c >= 11 && c <= 14) ? 64'd1 : 64'd0);
         check("t5_drain_done", 64'(bus.drain_done), (c == 15) ? 64'd1 : 64'd0);
         next_cycle();
      end
      bus.in_valid = 1'b0;
      @(negedge clk);
      check("t5_idle_advance", 64'(bus.advance), 64'd0);
      check("t5_idle_drain_done", 64'(bus.drain_done), 64'd0);
      check("t5_ovf", 64'(bus.ovf_err), 64'd0);
      next_cycle();
      @(negedge clk);
      check("t5_rerun_in_ready", 64'(bus.in_ready), 64'd1);
      next_cycle();

      // counter wrap on the narrow instance
      bus2.aes_enable = 1'b1;
      next_cycle();
      for (int c = 0; c <= 16; c++) begin
         bus2.in_valid = 1'b1;
         @(negedge clk);
         check("t6_in_ready", 64'(bus2.in_ready), 64'd1);
         check("t6_ctr", 64'(bus2.ctr_value), 64'(c % 16));
         next_cycle();
      end
      bus2.in_valid = 1'b0;
      @(negedge clk);
      check("t6_ctr_after_wrap", 64'(bus2.ctr_value), 64'd1);
      check("t6_ovf", 64'(bus2.ovf_err), 64'd0);
      next_cycle();

      // asynchronous reset with blocks in flight
      for (int c = 0; c < 3; c++) begin
         bus.in_valid = 1'b1;
         next_cycle();
      end
      bus.in_valid = 1'b0;
      next_cycle();
      next_cycle();
      #2;
      bus.in_valid = 1'b1;
      n_rst = 1'b0;
      #1;
      check("t7_rst_occupancy", 64'(bus.occupancy), 64'd0);
      check("t7_rst_stage_valid", 64'(bus.stage_valid), 64'd0);
      check("t7_rst_in_ready", 64'(bus.in_ready), 64'd0);
      check("t7_rst_advance", 64'(bus.advance), 64'd0);
      next_cycle();
      n_rst        = 1'b1;
      bus.in_valid = 1'b0;
      retired = 0;
      for (int c = 0; c < 16; c++) begin
         @(negedge clk);
         if (bus.data_output) retired++;
         next_cycle();
      end
      check("t7_no_data_output", 64'(retired), 64'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
